// File: rtl/softmax_exp_seq.sv
// Softmax exp sequencer: buffers N clamped logits, issues them one at a time to an
// external exp unit, accumulates the linearised results and streams the exp words out.
module softmax_exp_seq #(
  parameter int N       = 8,
  parameter int EXP_LAT = 0,
  parameter int SUM_W   = 32 + $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16:0]      in_data,
  output logic [16:0]      exp_x,
  input  logic [20:0]      exp_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [20:0]      out_data,
  output logic             out_last,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  output logic             busy
);

  localparam int               IDX_W    = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [1:0]       LAT      = 2'(EXP_LAT);
  localparam logic [15:0]      MAG_MAX  = 16'hA000;

  typedef enum logic [1:0] {S_LOAD, S_EXP, S_OUT} state_t;

  state_t state_reg, state_next;

  logic [16:0] lbuf [N];
  logic [20:0] ebuf [N];

  logic [IDX_W-1:0] wr_idx_reg, iss_idx_reg, rd_idx_reg;
  logic [1:0]       phase_reg;
  logic [SUM_W-1:0] acc_reg, sum_reg, acc_next;
  logic [SUM_W:0]   acc_sum;
  logic [16:0]      exp_x_reg, in_clamped;
  logic [20:0]      out_data_reg;
  logic [31:0]      term;
  logic [IDX_W-1:0] lbuf_raddr, ebuf_raddr;
  logic             load_beat, capture, out_fire;

  function automatic logic [16:0] clamp_logit(input logic [16:0] x);
    logic [15:0] mag;
    mag = (x[15:0] > MAG_MAX) ? MAG_MAX : x[15:0];
    // Negative zero collapses to plain zero so the exp unit sees one encoding.
    clamp_logit = (mag == 16'h0000) ? 17'h00000 : {x[16], mag};
  endfunction

  assign in_clamped = clamp_logit(in_data);

  // Linearised exp term m << e, saturating terms whose position is out of range.
  always_comb begin
    term     = (exp_y[20:16] > 5'd16) ? 32'hFFFF_FFFF : ({16'h0000, exp_y[15:0]} << exp_y[20:16]);
    acc_sum  = {1'b0, acc_reg} + {{(SUM_W - 31){1'b0}}, term};
    acc_next = acc_sum[SUM_W] ? {SUM_W{1'b1}} : acc_sum[SUM_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_LOAD;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    sum_valid  = 1'b0;
    busy       = 1'b0;
    load_beat  = 1'b0;
    capture    = 1'b0;
    out_fire   = 1'b0;
    case (state_reg)
      S_LOAD: begin
        in_ready  = 1'b1;
        load_beat = in_valid;
        if (load_beat && wr_idx_reg == LAST_IDX) state_next = S_EXP;
      end
      S_EXP: begin
        busy    = 1'b1;
        capture = (phase_reg == LAT);
        if (capture && iss_idx_reg == LAST_IDX) state_next = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        sum_valid = 1'b1;
        out_last  = (rd_idx_reg == LAST_IDX);
        out_fire  = out_ready;
        if (out_fire && rd_idx_reg == LAST_IDX) state_next = S_LOAD;
      end
      default: state_next = S_LOAD;
    endcase
  end

  // Single read port per buffer: prefetch element 0 on phase entry, else the next index.
  assign lbuf_raddr = (state_reg == S_LOAD) ? '0 : iss_idx_reg + IDX_ONE;
  assign ebuf_raddr = (state_reg == S_EXP)  ? '0 : rd_idx_reg + IDX_ONE;

  always_ff @(posedge clk) begin
    if (load_beat) lbuf[wr_idx_reg]  <= in_clamped;
    if (capture)   ebuf[iss_idx_reg] <= exp_y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx_reg   <= '0;
      iss_idx_reg  <= '0;
      rd_idx_reg   <= '0;
      phase_reg    <= '0;
      acc_reg      <= '0;
      sum_reg      <= '0;
      exp_x_reg    <= '0;
      out_data_reg <= '0;
    end else begin
      if (load_beat) begin
        wr_idx_reg <= wr_idx_reg + IDX_ONE;
        if (wr_idx_reg == LAST_IDX) begin
          acc_reg     <= '0;
          sum_reg     <= '0;
          iss_idx_reg <= '0;
          phase_reg   <= '0;
          exp_x_reg   <= lbuf[lbuf_raddr];
        end
      end
      if (state_reg == S_EXP) begin
        if (capture) begin
          acc_reg     <= acc_next;
          phase_reg   <= '0;
          iss_idx_reg <= iss_idx_reg + IDX_ONE;
          if (iss_idx_reg == LAST_IDX) begin
            sum_reg      <= acc_next;
            rd_idx_reg   <= '0;
            out_data_reg <= ebuf[ebuf_raddr];
          end else begin
            exp_x_reg <= lbuf[lbuf_raddr];
          end
        end else begin
          phase_reg <= phase_reg + 2'd1;
        end
      end
      if (out_fire) begin
        rd_idx_reg <= rd_idx_reg + IDX_ONE;
        if (rd_idx_reg != LAST_IDX) out_data_reg <= ebuf[ebuf_raddr];
      end
    end
  end

  assign exp_x    = exp_x_reg;
  assign out_data = out_data_reg;
  assign sum      = sum_reg;

endmodule

// File: tb/tb_softmax_exp_seq.sv
// Bench for softmax_exp_seq: two instances (combinational and 2-cycle exp unit stubs)
// checked against an array-based softmax-exp reference model.
module tb_softmax_exp_seq;

  localparam int N  = 8;
  localparam int SW = 32 + $clog2(N);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]    in_valid_v, in_ready_v, out_valid_v, out_ready_v, out_last_v, sum_valid_v, busy_v;
  logic [16:0]   in_data;
  logic [16:0]   exp_x_v [2];
  logic [20:0]   exp_y_v [2];
  logic [20:0]   out_data_v [2];
  logic [SW-1:0] sum_v [2];
  logic [16:0]   xd1, xd2;

  int          stub_mode;
  logic [20:0] stub_const;
  logic        sel;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_vec   = 0;

  function automatic logic [20:0] stub_f(input logic [16:0] x, input int mode, input logic [20:0] c);
    if (mode == 0) return c;
    return {x[15:11] ^ x[4:0], x[15:0] ^ 16'h5A5A ^ {x[16], 15'h0}};
  endfunction

  // Exp unit stubs: one combinational, one whose output follows exp_x two cycles late.
  always_ff @(posedge clk) begin
    xd1 <= exp_x_v[1];
    xd2 <= xd1;
  end
  assign exp_y_v[0] = stub_f(exp_x_v[0], stub_mode, stub_const);
  assign exp_y_v[1] = stub_f(xd2, stub_mode, stub_const);

  softmax_exp_seq #(.N(N), .EXP_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_data(in_data),
    .exp_x(exp_x_v[0]), .exp_y(exp_y_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_data(out_data_v[0]),
    .out_last(out_last_v[0]), .sum(sum_v[0]), .sum_valid(sum_valid_v[0]), .busy(busy_v[0])
  );

  softmax_exp_seq #(.N(N), .EXP_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_data(in_data),
    .exp_x(exp_x_v[1]), .exp_y(exp_y_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_data(out_data_v[1]),
    .out_last(out_last_v[1]), .sum(sum_v[1]), .sum_valid(sum_valid_v[1]), .busy(busy_v[1])
  );

  wire          o_in_ready  = in_ready_v[sel];
  wire          o_out_valid = out_valid_v[sel];
  wire          o_out_last  = out_last_v[sel];
  wire          o_sum_valid = sum_valid_v[sel];
  wire          o_busy      = busy_v[sel];
  wire [16:0]   o_exp_x     = exp_x_v[sel];
  wire [20:0]   o_out_data  = out_data_v[sel];
  wire [SW-1:0] o_sum       = sum_v[sel];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d): got %0h expected %0h", tag, sel, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model pieces, straight from the numeric rules.
  function automatic logic [16:0] ref_clamp(input logic [16:0] x);
    int mag;
    mag = int'(x[15:0]);
    if (mag > 40960) mag = 40960;
    if (mag == 0) return 17'h00000;
    return {x[16], 16'(mag)};
  endfunction

  function automatic logic [63:0] ref_term(input logic [20:0] w);
    int e;
    e = int'(w[20:16]);
    if (e > 16) return 64'hFFFF_FFFF;
    return 64'(w[15:0]) * (64'd1 << e);
  endfunction

  function automatic logic [16:0] rand_logit();
    logic [16:0] v;
    case ($urandom_range(3))
      0:       v = 17'h10000;
      1:       v = {1'($urandom), 16'hA000 + 16'($urandom_range(64))};
      default: v = 17'($urandom);
    endcase
    return v;
  endfunction

  task automatic load_vector(input logic [16:0] lg [N]);
    int  k, guard;
    logic v;
    k = 0;
    guard = 0;
    while (k < N && guard < 200) begin
      check("in_ready_load", 64'(o_in_ready), 64'd1);
      v = ($urandom_range(3) != 0);
      in_valid_v[sel] = v;
      in_data = v ? lg[k] : 17'($urandom);
      tick();
      if (v) k++;
      guard++;
    end
    check("load_beats", 64'(k), 64'(N));
    // Keep offering garbage afterwards; it must be ignored outside LOAD.
    in_valid_v[sel] = 1'b1;
    in_data = 17'($urandom);
  endtask

  task automatic run_vector(input logic s, input int bp, input logic [16:0] lg [N]);
    int          lat, c, j, oc, busy_cnt;
    logic [16:0] cl [N];
    logic [20:0] ew [N];
    logic [63:0] acc, sat_max, hd;
    logic        r, held, hl;
    sel = s;
    #1;
    lat = s ? 2 : 0;
    sat_max = (64'd1 << SW) - 64'd1;
    acc = 64'd0;
    for (int k = 0; k < N; k++) begin
      cl[k] = ref_clamp(lg[k]);
      ew[k] = stub_f(cl[k], stub_mode, stub_const);
      acc += ref_term(ew[k]);
      if (acc > sat_max) acc = sat_max;
    end
    load_vector(lg);
    check("in_ready_drop", 64'(o_in_ready), 64'd0);
    c = 0;
    busy_cnt = 0;
    while (!o_out_valid && c < 200) begin
      if (c < N * (lat + 1)) check("exp_x", 64'(o_exp_x), 64'(cl[c / (lat + 1)]));
      check("in_ready_exp", 64'(o_in_ready), 64'd0);
      busy_cnt += int'(o_busy);
      in_data = 17'($urandom);
      tick();
      c++;
    end
    check("exp_len", 64'(c), 64'(N * (lat + 1)));
    check("sum", 64'(o_sum), acc);
    j = 0;
    oc = 0;
    held = 1'b0;
    hd = '0;
    hl = 1'b0;
    while (j < N && oc < 300) begin
      if (held) begin
        check("stall_data", 64'(o_out_data), hd);
        check("stall_last", 64'(o_out_last), 64'(hl));
      end
      check("out_valid", 64'(o_out_valid), 64'd1);
      check("sum_valid", 64'(o_sum_valid), 64'd1);
      check("in_ready_out", 64'(o_in_ready), 64'd0);
      r = (bp == 0) ? 1'b1 : (bp == 1) ? (oc % 3 == 0) : 1'($urandom_range(1));
      out_ready_v[sel] = r;
      if (r) begin
        check("out_data", 64'(o_out_data), 64'(ew[j]));
        check("out_last", 64'(o_out_last), 64'(j == N - 1));
        j++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        hd = 64'(o_out_data);
        hl = o_out_last;
      end
      busy_cnt += int'(o_busy);
      in_data = 17'($urandom);
      tick();
      oc++;
    end
    out_ready_v = '0;
    in_valid_v = '0;
    check("out_beats", 64'(j), 64'(N));
    check("idle_out_valid", 64'(o_out_valid), 64'd0);
    check("idle_sum_valid", 64'(o_sum_valid), 64'd0);
    check("idle_in_ready", 64'(o_in_ready), 64'd1);
    check("idle_busy", 64'(o_busy), 64'd0);
    check("sum_hold", 64'(o_sum), acc);
    if (bp == 0) check("busy_cycles", 64'(busy_cnt), 64'(N * (lat + 1) + N));
    $display("[TB] vector %0d dut%0d bp=%0d mode=%0d sum=%0h out_cycles=%0d", n_vec, s, bp, stub_mode, acc, oc);
    n_vec++;
  endtask

  logic [16:0] lg [N];

  initial begin
    rst_n = 1'b0;
    in_valid_v = '0;
    out_ready_v = '0;
    in_data = '0;
    stub_mode = 0;
    stub_const = 21'h108000;
    sel = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("rst_in_ready", 64'(o_in_ready), 64'd1);
      check("rst_out_valid", 64'(o_out_valid), 64'd0);
      check("rst_out_last", 64'(o_out_last), 64'd0);
      check("rst_sum_valid", 64'(o_sum_valid), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_exp_x", 64'(o_exp_x), 64'd0);
      check("rst_out_data", 64'(o_out_data), 64'd0);
      check("rst_sum", 64'(o_sum), 64'd0);
    end
    rst_n = 1'b1;
    tick();

    // Fixed stub, all logits 1.0: each term 0x8000_0000.
    for (int k = 0; k < N; k++) lg[k] = 17'h01000;
    run_vector(1'b0, 0, lg);
    check("const_sum", 64'(o_sum), 64'h4_0000_0000);

    // Clamp corners first, then random fill.
    stub_mode = 1;
    lg[0] = 17'h0F000; lg[1] = 17'h1F000; lg[2] = 17'h10000; lg[3] = 17'h0A000;
    for (int k = 4; k < N; k++) lg[k] = rand_logit();
    run_vector(1'b0, 0, lg);
    run_vector(1'b1, 0, lg);

    // Backpressure 1,0,0 pattern on both latencies.
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < N; k++) lg[k] = rand_logit();
      run_vector(1'(s), 1, lg);
    end

    // Saturated terms: e=31, m=FFFF.
    stub_mode = 0;
    stub_const = {5'd31, 16'hFFFF};
    for (int k = 0; k < N; k++) lg[k] = rand_logit();
    run_vector(1'b0, 0, lg);
    check("sat_sum", 64'(o_sum), 64'h7_FFFF_FFF8);
    run_vector(1'b1, 2, lg);

    // Random vectors, random backpressure.
    stub_mode = 1;
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < N; k++) lg[k] = rand_logit();
      run_vector(1'($urandom_range(1)), int'($urandom_range(2)), lg);
    end

    // Reset one cycle after element 3 capture on the EXP_LAT=2 instance.
    sel = 1'b1;
    #1;
    for (int k = 0; k < N; k++) lg[k] = rand_logit();
    load_vector(lg);
    in_valid_v = '0;
    repeat (4 * 3) tick();
    check("pre_rst_busy", 64'(o_busy), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_in_ready", 64'(o_in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(o_out_valid), 64'd0);
    check("mid_rst_sum_valid", 64'(o_sum_valid), 64'd0);
    check("mid_rst_sum", 64'(o_sum), 64'd0);
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_exp_x", 64'(o_exp_x), 64'd0);
    $display("[TB] vector %0d dut1 abandoned by reset", n_vec);
    for (int k = 0; k < N; k++) lg[k] = rand_logit();
    run_vector(1'b1, 2, lg);
    run_vector(1'b0, 0, lg);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
